cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Round-robin arbiter that shares the single cache-bus master port (`cbus_req_t`/`cbus_resp_t`) between several cache-side requesters, e.g. I-cache and D-cache refill/write-back engines. It sits between the caches and the AXI bridge. It grants one requester at a time, holds the grant for the whole burst, and routes beat responses back to the granted requester only.

## Interface
- `NUM_INPUTS`, default 2: number of requester ports (≥1).
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on rising edge of `clk`.
- `ireqs`  in  `cbus_req_t[NUM_INPUTS]`: per-requester bus requests.
- `iresps`  out  `cbus_resp_t[NUM_INPUTS]`: per-requester responses.
- `oreq`  out  `cbus_req_t`: request to shared bus / AXI bridge.
- `oresp`  in  `cbus_resp_t`: response from shared bus.

## Operation
- State machine `IDLE`, `BUSY`. Registers:
  - `state`
  - `grant_idx` (`$clog2(NUM_INPUTS)` bits, min 1)
  - `rr_ptr` (same width): highest-priority port for the next pick.
- IDLE:
  - Pick the first port with `ireqs[i].valid`, scanning from `rr_ptr` upward modulo `NUM_INPUTS`.
  - If a port is found, latch `grant_idx` and go to BUSY next cycle.
  - If none, stay in IDLE.
- BUSY:
  - `oreq = ireqs[grant_idx]`; all fields pass through unchanged, including per-beat `data`/`strobe` for writes.
  - `iresps[grant_idx] = oresp`; all other `iresps` are all-zero.
  - On `oresp.ready && oresp.last`, go to IDLE and set `rr_ptr = grant_idx + 1`, wrapping to 0 at `NUM_INPUTS`.
- Outside BUSY, `oreq` is all-zero and every `iresps` is all-zero.
- Grant is held until `last`, even if the granted requester drops `valid` mid-burst. In that case `oreq.valid` follows the requester (forwarded as-is). Protocol compliance is the requester's responsibility; the arbiter never switches mid-burst.
- `oresp.ready` without `last` keeps the arbiter in BUSY.
- `oresp.ready && oresp.last` while `oreq.valid = 0` still ends the grant.
- `NUM_INPUTS = 1`: the pick is always port 0 and `rr_ptr` stays 0.

## Timing
- Reset (`reset = 0` at an edge):
  - `state = IDLE`, `grant_idx = 0`, `rr_ptr = 0`.
  - Outputs are all-zero from the following cycle.
  - Reset mid-burst abandons the burst immediately. The downstream bridge is reset by the same signal.
- Grant latency: a request seen valid in IDLE at edge N appears on `oreq` during cycle N+1 (one registered cycle).
- Release: `last` beat accepted at edge M puts the arbiter in IDLE during cycle M+1. A new request visible in that cycle is forwarded in cycle M+2. This gives a minimum 1 idle cycle between back-to-back bursts.
- The BUSY datapath is purely combinational: `ireqs → oreq` and `oresp → iresps` add zero latency.
- Simultaneous requests in IDLE: the winner is determined only by `rr_ptr`. The loser keeps `valid` high and is served next.
- Starvation bound: a continuously valid requester is granted within `NUM_INPUTS − 1` other bursts.

## Structure
- Bus types `cbus_req_t`, `cbus_resp_t`, `mlen_t` and `msize_t` come from the shared `common` package.
- Add `arb_state_t` (enum `IDLE`, `BUSY`, 1 bit) to the `common` package.
- Sub-module `rr_picker`: combinational.
  - Inputs: valid vector, `rr_ptr`.
  - Outputs: `found`, `idx`.
  - Implementation: doubled-vector priority encoder.
- Top level holds the FSM, registers and muxes.

## Test plan
- Reset: hold `reset = 0` for 3 cycles while both ports are valid → `oreq.valid = 0` and all `iresps` are zero throughout. The grant goes to port 0 the cycle after release.
- Single read: port 1 requests `addr = 0x80000000`, `len = MLEN16`; bridge returns 16 beats with `last` on beat 16 →
  - port 1 receives exactly 16 `ready` pulses and one `last`;
  - port 0 sees zero;
  - `rr_ptr = 0` afterwards.
- Round robin: ports 0 and 1 both hold valid continuously over 4 bursts of `MLEN4` → grant order is 0,1,0,1, with exactly one idle cycle between bursts.
- Write pass-through: port 0 write, `len = MLEN8`, `strobe = 0xFF`, data changes per beat → `oreq.data`/`oreq.strobe` equal port 0 inputs in the same cycle on every beat.
- Mid-burst arrival: port 1 asserts valid on beat 3 of port 0's `MLEN16` burst → port 0 is not preempted, and port 1 is granted 1 cycle after port 0's `last`.
- Reset mid-burst: assert `reset = 0` on beat 5 of 16 → next cycle `state = IDLE` and outputs are zero. After reset, a pending port 1 request is granted only after port 0, because `rr_ptr` resets to 0.

Source files
------------

// File: rtl/common_pkg.sv
// common: shared cache-bus types and the arbiter state encoding.
package common;
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    mlen_t       len;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// rr_picker: first valid port at or above ptr, modulo N, via a doubled-vector priority encoder.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  localparam logic [W:0] NN = (W+1)'(N);
  logic [N-1:0] rot;
  logic [W:0] sum;
  always_comb begin
    rot = N'({valid, valid} >> ptr);
    found = 1'b0;
    idx = '0;
    sum = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) begin
      found = 1'b1;
      sum = {1'b0, ptr} + (W+1)'(i);
      idx = sum >= NN ? W'(sum - NN) : sum[W-1:0];
    end
  end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin share of one cache-bus master port; grant held for a whole burst.
module cbus_arbiter
  import common::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam logic [W-1:0] LAST = W'(NUM_INPUTS - 1);
  arb_state_t state, state_n;
  logic [W-1:0] grant_idx, grant_n, rr_ptr, ptr_n, pick;
  logic [NUM_INPUTS-1:0] valids;
  logic found, done, take;
  always_comb for (int i = 0; i < NUM_INPUTS; i++) valids[i] = ireqs[i].valid;
  rr_picker #(.N(NUM_INPUTS), .W(W)) u_picker (
    .valid(valids),
    .ptr(rr_ptr),
    .found(found),
    .idx(pick)
  );
  // a last beat ends the grant even if the requester has already dropped valid
  assign done = state == BUSY && oresp.ready && oresp.last;
  assign take = state == IDLE && found;
  always_comb begin
    state_n = done ? IDLE : take ? BUSY : state;
    grant_n = take ? pick : grant_idx;
    ptr_n = done ? (grant_idx == LAST ? '0 : grant_idx + 1'b1) : rr_ptr;
    oreq = state == BUSY ? ireqs[grant_idx] : '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      iresps[i] = state == BUSY && grant_idx == W'(i) ? oresp : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      grant_idx <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      grant_idx <= grant_n;
      rr_ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed vectors and burst sequences for the two-port cache-bus arbiter.
module tb_cbus_arbiter;
  import common::*;
  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h8000_0000, Z = 32'h0;
  logic clk = 1'b0, reset = 1'b0;
  cbus_req_t ireqs [2];
  cbus_resp_t iresps [2];
  cbus_req_t oreq;
  cbus_resp_t oresp;
  int checks = 0, fails = 0;
  typedef struct packed {
    logic [3:0]  in;
    logic        oval;
    logic [31:0] oaddr;
    logic [1:0]  r;
  } vec_t;
  vec_t vecs [15];
  cbus_arbiter #(.NUM_INPUTS(2)) dut (
    .clk(clk),
    .reset(reset),
    .ireqs(ireqs),
    .iresps(iresps),
    .oreq(oreq),
    .oresp(oresp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!oreq.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, oreq.valid, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int beat, bursts, gap, bad;
    int order [4];
    int gaps [4];
    int r1cnt, l1cnt, p0cnt;
    logic [63:0] d;
    vecs[0]  = '{4'b1100, 1'b0, Z,  2'b00};
    vecs[1]  = '{4'b1110, 1'b1, A0, 2'b10};
    vecs[2]  = '{4'b1111, 1'b1, A0, 2'b10};
    vecs[3]  = '{4'b1100, 1'b0, Z,  2'b00};
    vecs[4]  = '{4'b1111, 1'b1, A1, 2'b01};
    vecs[5]  = '{4'b0100, 1'b0, Z,  2'b00};
    vecs[6]  = '{4'b1100, 1'b1, A1, 2'b00};
    vecs[7]  = '{4'b1010, 1'b0, A1, 2'b01};
    vecs[8]  = '{4'b1011, 1'b0, A1, 2'b01};
    vecs[9]  = '{4'b1000, 1'b0, Z,  2'b00};
    vecs[10] = '{4'b1011, 1'b1, A0, 2'b10};
    vecs[11] = '{4'b1000, 1'b0, Z,  2'b00};
    vecs[12] = '{4'b1011, 1'b1, A0, 2'b10};
    vecs[13] = '{4'b0000, 1'b0, Z,  2'b00};
    vecs[14] = '{4'b0011, 1'b0, Z,  2'b00};
    ireqs[0] = '0;
    ireqs[0].addr = A0;
    ireqs[0].len = MLEN4;
    ireqs[1] = '0;
    ireqs[1].addr = A1;
    ireqs[1].len = MLEN4;
    oresp = '0;
    ireqs[0].valid = 1'b1;
    ireqs[1].valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_oreq_valid", oreq.valid, 0);
      chk("rst_iresp0", iresps[0], 0);
      chk("rst_iresp1", iresps[1], 0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_idle", oreq.valid, 0);
    @(negedge clk);
    chk("rel_grant_valid", oreq.valid, 1);
    chk("rel_grant_port0", oreq.addr, A0);
    oresp.ready = 1'b1;
    oresp.last = 1'b1;
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].valid = 1'b0;
    ireqs[1].valid = 1'b0;
    ireqs[1].len = MLEN16;
    ireqs[1].valid = 1'b1;
    wait_valid("rd_grant");
    chk("rd_addr", oreq.addr, A1);
    chk("rd_len", oreq.len, MLEN16);
    r1cnt = 0;
    l1cnt = 0;
    p0cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16) begin
        oresp.ready = 1'b1;
        oresp.last = c == 15;
      end else oresp = '0;
      if (c == 16) ireqs[1].valid = 1'b0;
      #1;
      r1cnt += int'(iresps[1].ready);
      l1cnt += int'(iresps[1].last);
      p0cnt += int'(iresps[0].ready | iresps[0].last);
      @(negedge clk);
    end
    chk("rd_ready_pulses", r1cnt, 16);
    chk("rd_last_pulses", l1cnt, 1);
    chk("rd_port0_quiet", p0cnt, 0);
    chk("rd_rr_ptr", dut.rr_ptr, 0);
    @(posedge clk);
    #1 ireqs[0].valid = 1'b1;
    ireqs[1].valid = 1'b1;
    ireqs[1].len = MLEN4;
    beat = 0;
    bursts = 0;
    gap = 0;
    for (int c = 0; c < 60 && bursts < 4; c++) begin
      @(negedge clk);
      if (oreq.valid) begin
        if (beat == 0) begin
          order[bursts] = oreq.addr == A1 ? 1 : 0;
          gaps[bursts] = gap;
          gap = 0;
        end
        oresp.ready = 1'b1;
        oresp.last = beat == 3;
        if (beat == 3) begin
          beat = 0;
          bursts++;
        end else beat++;
      end else begin
        oresp = '0;
        gap++;
      end
    end
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].valid = 1'b0;
    ireqs[1].valid = 1'b0;
    chk("rr_bursts", bursts, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), order[k], k % 2);
    for (int k = 1; k < 4; k++) chk($sformatf("rr_gap%0d", k), gaps[k], 1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1 ireqs[0].valid = vecs[i].in[3];
      ireqs[1].valid = vecs[i].in[2];
      oresp.ready = vecs[i].in[1];
      oresp.last = vecs[i].in[0];
      @(negedge clk);
      chk($sformatf("vec%0d_oval", i), oreq.valid, vecs[i].oval);
      chk($sformatf("vec%0d_oaddr", i), oreq.addr, vecs[i].oaddr);
      chk($sformatf("vec%0d_r0", i), iresps[0].ready, vecs[i].r[1]);
      chk($sformatf("vec%0d_r1", i), iresps[1].ready, vecs[i].r[0]);
    end
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].valid = 1'b1;
    ireqs[0].is_write = 1'b1;
    ireqs[0].len = MLEN8;
    ireqs[0].strobe = 8'hFF;
    ireqs[1].valid = 1'b0;
    wait_valid("wr_grant");
    for (int b = 0; b < 8; b++) begin
      d = 64'hA5A5_0000_0000_0000 | 64'(b * 3 + 1);
      ireqs[0].data = d;
      oresp.ready = 1'b1;
      oresp.last = b == 7;
      #1;
      chk($sformatf("wr_data%0d", b), oreq.data, d);
      chk($sformatf("wr_strobe%0d", b), oreq.strobe, 8'hFF);
      chk($sformatf("wr_write%0d", b), oreq.is_write, 1);
      if (b < 7) @(negedge clk);
    end
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].valid = 1'b0;
    ireqs[0].is_write = 1'b0;
    ireqs[0].strobe = 8'h00;
    ireqs[0].len = MLEN16;
    ireqs[0].valid = 1'b1;
    wait_valid("mid_grant");
    bad = 0;
    for (int b = 0; b < 16; b++) begin
      if (b == 2) ireqs[1].valid = 1'b1;
      oresp.ready = 1'b1;
      oresp.last = b == 15;
      #1;
      if (oreq.addr !== A0 || iresps[1] !== '0) bad++;
      if (b < 15) @(negedge clk);
    end
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].valid = 1'b0;
    chk("mid_no_preempt", bad, 0);
    @(negedge clk);
    chk("mid_idle_gap", oreq.valid, 0);
    @(negedge clk);
    chk("mid_port1_valid", oreq.valid, 1);
    chk("mid_port1_addr", oreq.addr, A1);
    oresp.ready = 1'b1;
    oresp.last = 1'b1;
    @(posedge clk);
    #1 oresp = '0;
    ireqs[1].valid = 1'b0;
    ireqs[0].len = MLEN1;
    ireqs[0].valid = 1'b1;
    wait_valid("pre_grant");
    chk("pre_addr", oreq.addr, A0);
    oresp.ready = 1'b1;
    oresp.last = 1'b1;
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].len = MLEN16;
    wait_valid("rstmid_grant");
    chk("rstmid_addr", oreq.addr, A0);
    for (int b = 0; b < 5; b++) begin
      if (b == 1) ireqs[1].valid = 1'b1;
      oresp.ready = 1'b1;
      oresp.last = 1'b0;
      if (b == 4) reset = 1'b0;
      if (b < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    oresp = '0;
    @(negedge clk);
    chk("rstmid_state", dut.state, IDLE);
    chk("rstmid_oreq", oreq, 0);
    chk("rstmid_iresp0", iresps[0], 0);
    chk("rstmid_iresp1", iresps[1], 0);
    chk("rstmid_rr_ptr", dut.rr_ptr, 0);
    @(negedge clk);
    chk("rstmid_regrant_valid", oreq.valid, 1);
    chk("rstmid_regrant_port0", oreq.addr, A0);
    oresp.ready = 1'b1;
    oresp.last = 1'b1;
    @(posedge clk);
    #1 oresp = '0;
    ireqs[0].valid = 1'b0;
    ireqs[1].valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
